// File: rtl/branch_resolve.sv
// branch_resolve: resolves one RV32I conditional branch per cycle.
//   Takes the branch op plus same-cycle comparator flags (less_than/equal),
//   computes direction, next PC, mispredict/illegal/misaligned flags and
//   holds them in a single-entry output register (1-cycle latency).
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        op handshake; in_funct3, in_pc, in_imm,
//                            in_pred_taken, in_pred_target op payload
//   unsigned_cmp             compare mode to the operand comparator
//   less_than, equal         comparator result for the offered op
//   flush                    synchronous kill of the held/incoming op
//   out_valid/out_ready      result handshake; out_taken, out_next_pc,
//                            out_mispredict, out_illegal, out_misaligned
//   mispredict_count         saturating count of delivered mispredicts
module branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             unsigned_cmp,
  input  logic             less_than,
  input  logic             equal,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;
    logic            illegal;
    logic            misaligned;
  } res_t;

  state_t           state, state_nxt;
  res_t             res_q, res_d;
  logic             accept, handshake;
  logic             taken, illegal;
  logic [XLEN-1:0]  target, fallthrough;
  logic [CNT_W-1:0] cnt_q;

  // BLTU/BGEU (funct3 11x) need the unsigned comparison.
  assign unsigned_cmp = in_funct3[1];

  assign out_valid   = (state == FULL);
  // A slot draining this cycle can be refilled this cycle; flush blocks intake.
  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign handshake   = out_valid && out_ready;

  assign target      = in_pc + in_imm;
  assign fallthrough = in_pc + XLEN'(4);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (in_funct3)
      3'b000:         taken = equal;
      3'b001:         taken = !equal;
      3'b100, 3'b110: taken = less_than;
      3'b101, 3'b111: taken = !less_than;
      default:        illegal = 1'b1;  // 010/011: taken stays 0
    endcase
  end

  // taken is already 0 for illegal encodings, so the taken-gated flags
  // and the fallthrough select need no extra illegal masking.
  always_comb begin
    res_d            = '0;
    res_d.taken      = taken;
    res_d.next_pc    = taken ? target : fallthrough;
    res_d.mispredict = !illegal && ((taken != in_pred_taken) ||
                                    (taken && (in_pred_target != target)));
    res_d.illegal    = illegal;
    res_d.misaligned = taken && (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)          state_nxt = EMPTY;
    else if (accept)    state_nxt = FULL;
    else if (handshake) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         res_q <= '0;
    else if (accept) res_q <= res_d;
  end

  // A handshake in a flush cycle still delivers, so it still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (handshake && res_q.mispredict && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign out_taken        = res_q.taken;
  assign out_next_pc      = res_q.next_pc;
  assign out_mispredict   = res_q.mispredict;
  assign out_illegal      = res_q.illegal;
  assign out_misaligned   = res_q.misaligned;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: drives real operand values through a bench-side
// comparator, predicts results from RV32I branch semantics, and checks the
// DUT every cycle plus a few literal scenarios.
module tb_branch_resolve;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_pred_target;
  logic        in_pred_taken;
  logic        unsigned_cmp, less_than, equal, flush;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, out_misaligned;
  logic [31:0] out_next_pc;
  logic [15:0] mispredict_count;
  logic [31:0] rs1, rs2;

  int tests = 0;
  int fails = 0;

  branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .unsigned_cmp(unsigned_cmp), .less_than(less_than), .equal(equal),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_next_pc(out_next_pc),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_misaligned(out_misaligned), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand comparator in the mode the DUT requests.
  assign equal     = (rs1 == rs2);
  assign less_than = unsigned_cmp ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the result slot as plain variables.
  bit          m_valid;
  bit          m_taken, m_misp, m_ill, m_mis;
  bit   [31:0] m_next;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0; m_mis = 0; m_next = 0; m_cnt = 0;
    end else begin
      bit hs, acc, tk, ill;
      bit [31:0] tgt;
      hs  = m_valid && out_ready;
      acc = in_valid && !flush && (!m_valid || out_ready);
      if (hs && m_misp && m_cnt < 65535) m_cnt++;
      if (acc) begin
        ill = 0;
        case (in_funct3)
          3'd0: tk = (rs1 == rs2);
          3'd1: tk = (rs1 != rs2);
          3'd4: tk = ($signed(rs1) <  $signed(rs2));
          3'd5: tk = ($signed(rs1) >= $signed(rs2));
          3'd6: tk = (rs1 <  rs2);
          3'd7: tk = (rs1 >= rs2);
          default: begin tk = 0; ill = 1; end
        endcase
        tgt     = in_pc + in_imm;
        m_taken = tk;
        m_ill   = ill;
        m_next  = tk ? tgt : in_pc + 32'd4;
        m_misp  = !ill && (tk != in_pred_taken || (tk && in_pred_target != tgt));
        m_mis   = tk && (tgt % 4 != 0);
        m_valid = 1;
      end else if (flush || hs) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, !flush && (!m_valid || out_ready));
      chk("unsigned_cmp", unsigned_cmp, in_funct3[1]);
      chk("out_valid", out_valid, m_valid);
      chk("count", mispredict_count, m_cnt);
      if (m_valid) begin
        chk("taken", out_taken, m_taken);
        chk("next_pc", out_next_pc, m_next);
        chk("mispredict", out_mispredict, m_misp);
        chk("illegal", out_illegal, m_ill);
        chk("misaligned", out_misaligned, m_mis);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic pt, input logic [31:0] ptgt);
    in_valid = 1; in_funct3 = f3; in_pc = pc; in_imm = imm;
    rs1 = a; rs2 = b; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_taken"}, out_taken, 0);
    chk({tag, "_next"}, out_next_pc, 0);
    chk({tag, "_misp"}, out_mispredict, 0);
    chk({tag, "_ill"}, out_illegal, 0);
    chk({tag, "_mis"}, out_misaligned, 0);
    chk({tag, "_cnt"}, mispredict_count, 0);
  endtask

  logic [31:0] pool [4];

  initial begin
    rst = 1; in_valid = 0; in_funct3 = 0; in_pc = 0; in_imm = 0; in_pred_taken = 0;
    in_pred_target = 0; rs1 = 0; rs2 = 0; flush = 0; out_ready = 0;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h8000_0000; pool[3] = 32'hFFFF_FFFF;
    #2 chk_zero_outputs("reset");
    step(); rst = 0;

    // BEQ taken, predicted not-taken
    op(3'b000, 32'h1000, 32'h20, 5, 5, 0, 0);
    step(); in_valid = 0;
    @(negedge clk);
    chk("beq_valid", out_valid, 1);
    chk("beq_taken", out_taken, 1);
    chk("beq_next", out_next_pc, 32'h1020);
    chk("beq_misp", out_mispredict, 1);
    step(); out_ready = 1;
    step(); out_ready = 0;
    @(negedge clk);
    chk("beq_count", mispredict_count, 1);

    // BLTU not taken, fallthrough wraps
    step(); op(3'b110, 32'hFFFF_FFFC, 32'h8, 5, 3, 0, 0);
    #1 chk("bltu_ucmp", unsigned_cmp, 1);
    chk("bltu_lt", less_than, 0);
    step(); in_valid = 0;
    @(negedge clk);
    chk("bltu_next", out_next_pc, 32'h0);
    chk("bltu_misp", out_mispredict, 0);
    step(); out_ready = 1;
    step(); out_ready = 0;

    // Illegal encoding
    op(3'b010, 32'h2000, 32'h40, 1, 1, 1, 32'h2040);
    step(); in_valid = 0;
    @(negedge clk);
    chk("ill_flag", out_illegal, 1);
    chk("ill_taken", out_taken, 0);
    chk("ill_misp", out_mispredict, 0);
    chk("ill_next", out_next_pc, 32'h2004);
    step(); out_ready = 1;
    step(); out_ready = 0;
    @(negedge clk);
    chk("ill_count", mispredict_count, 1);

    // Misaligned taken target, then flush while stalled
    step(); op(3'b000, 32'h100, 32'h2, 7, 7, 1, 32'h102);
    step(); in_valid = 0;
    @(negedge clk);
    chk("mis_flag", out_misaligned, 1);
    chk("mis_misp", out_mispredict, 0);
    step(); flush = 1;
    step(); flush = 0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_count", mispredict_count, 1);

    // Back-to-back mispredicts to saturate the counter
    step(); op(3'b000, 32'h3000, 32'h10, 9, 9, 0, 0); out_ready = 1;
    for (int i = 0; i < 65545; i++) step();
    in_valid = 0;
    @(negedge clk);
    chk("sat_count", mispredict_count, 16'hFFFF);

    // Stall with a held result, then async reset without a clock edge
    step(); op(3'b001, 32'h4000, 32'h8, 1, 2, 0, 0); out_ready = 0;
    step(); in_valid = 0;
    step();
    #2 rst = 1;
    #1 chk_zero_outputs("async_rst");
    step(); rst = 0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] r;
      r = $urandom;
      in_valid       = ($urandom_range(0, 9) < 8);
      in_funct3      = 3'($urandom_range(0, 7));
      in_pc          = $urandom & 32'hFFFF_FFFC;
      in_imm         = {{19{r[12]}}, r[12:0]};
      rs1            = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 3)] : $urandom;
      rs2            = ($urandom_range(0, 2) == 0) ? rs1 : pool[$urandom_range(0, 3)];
      in_pred_taken  = 1'($urandom_range(0, 1));
      in_pred_target = ($urandom_range(0, 1) != 0) ? in_pc + in_imm : $urandom;
      flush          = ($urandom_range(0, 9) == 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
